// File: rtl/project_pkg.sv
// Shared types for the 8-bit core: opcodes, register names, ALU ops,
// sequencer states and writeback-source encodings.
package project_pkg;

  typedef enum logic [3:0] {
    OP_NOP   = 4'h0,
    OP_ADD   = 4'h1,
    OP_ADDI  = 4'h2,
    OP_SUB   = 4'h3,
    OP_AND   = 4'h4,
    OP_OR    = 4'h5,
    OP_XOR   = 4'h6,
    OP_LW    = 4'h7,
    OP_SW    = 4'h8,
    OP_COPY  = 4'h9,
    OP_WO    = 4'hA,
    OP_RO    = 4'hB,
    OP_JEQ   = 4'hC,
    OP_RSV_D = 4'hD,
    OP_RSV_E = 4'hE,
    OP_RSV_F = 4'hF
  } e_instr;

  typedef enum logic [1:0] {
    REG_R0 = 2'd0,
    REG_R1 = 2'd1,
    REG_R2 = 2'd2,
    REG_R3 = 2'd3
  } e_reg;

  typedef enum logic [2:0] {
    ALU_ADD  = 3'd0,
    ALU_SUB  = 3'd1,
    ALU_AND  = 3'd2,
    ALU_OR   = 3'd3,
    ALU_XOR  = 3'd4,
    ALU_PASS = 3'd5
  } e_alu_op;

  typedef enum logic [2:0] {
    S_FETCH = 3'd0,
    S_IMM   = 3'd1,
    S_EXEC  = 3'd2,
    S_MEM   = 3'd3,
    S_IO    = 3'd4
  } e_seq_state;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_IO  = 2'd2;

  // Bit n set: opcode n is followed by an immediate byte (ADDI, LW, SW, JEQ).
  localparam logic [15:0] IMM_MASK_DEFAULT = 16'h1184;

  function automatic logic is_io_op(input e_instr op);
    return (op == OP_WO) || (op == OP_RO);
  endfunction

endpackage

// File: rtl/bus_req_hold.sv
// Memory bus request port: the owner holds i_req until o_done, and the
// owning state's register captures o_rdata in that same cycle.
module bus_req_hold (
  input  logic       i_req,
  input  logic       i_we,
  input  logic [7:0] i_addr,
  input  logic [7:0] i_wdata,
  output logic       o_done,
  output logic [7:0] o_rdata,
  output logic       mem_req,
  output logic       mem_we,
  output logic [7:0] mem_addr,
  output logic [7:0] mem_wdata,
  input  logic [7:0] mem_rdata,
  input  logic       mem_ack
);

  // Handshake: a transfer completes in the cycle where mem_req && mem_ack;
  // an ack with mem_req low is not a completion and is dropped here.
  assign mem_req   = i_req;
  assign mem_we    = i_req & i_we;
  assign mem_addr  = i_addr;
  assign mem_wdata = i_wdata;
  assign o_done    = i_req & mem_ack;
  assign o_rdata   = mem_rdata;

endmodule

// File: rtl/instr_sequencer.sv
// Fetch/execute sequencer: owns PC and IR, fetches the immediate byte and
// stalls across memory and I/O handshakes, emitting a one-cycle exec_en.
module instr_sequencer
  import project_pkg::*;
#(
  parameter logic [7:0]  RESET_PC = 8'h00,
  parameter logic [15:0] IMM_MASK = IMM_MASK_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic       mem_req,
  output logic       mem_we,
  output logic [7:0] mem_addr,
  output logic [7:0] mem_wdata,
  input  logic [7:0] mem_rdata,
  input  logic       mem_ack,
  input  logic [7:0] rt_data,
  input  logic       zero,
  output logic [7:0] ir,
  output logic [7:0] imm,
  output logic [7:0] pc,
  output logic       exec_en,
  output logic [1:0] wb_sel,
  output logic [7:0] wb_data,
  output logic       io_wvalid,
  input  logic       io_wready,
  input  logic       io_rvalid,
  input  logic [7:0] io_rdata,
  output logic       io_rready,
  output e_seq_state dbg_state
);

  e_seq_state r_state;
  e_seq_state w_next;
  logic [7:0] r_pc;
  logic [7:0] r_ir;
  logic [7:0] r_imm;
  logic [7:0] r_wb_data;

  logic       w_req;
  logic       w_req_gated;
  logic       w_we;
  logic [7:0] w_addr;
  logic       w_done;
  logic [7:0] w_rdata;
  logic       w_exec;
  logic       w_wvalid;
  logic       w_rready;
  logic [1:0] w_wb_sel;
  e_instr     w_cur_op;
  e_instr     w_new_op;

  assign w_cur_op = e_instr'(r_ir[7:4]);
  assign w_new_op = e_instr'(w_rdata[7:4]);

  // Reset is FETCH, which requests; gating with rst_n keeps mem_req low
  // while reset is held and drops it the moment reset asserts.
  assign w_req_gated = w_req & rst_n;

  bus_req_hold u_bus (
    .i_req     (w_req_gated),
    .i_we      (w_we),
    .i_addr    (w_addr),
    .i_wdata   (rt_data),
    .o_done    (w_done),
    .o_rdata   (w_rdata),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack)
  );

  always_comb begin
    w_next   = r_state;
    w_req    = 1'b0;
    w_we     = 1'b0;
    w_addr   = r_pc;
    w_exec   = 1'b0;
    w_wvalid = 1'b0;
    w_rready = 1'b0;
    w_wb_sel = WB_ALU;
    case (r_state)
      S_FETCH: begin
        w_req = 1'b1;
        if (w_done) begin
          if (IMM_MASK[w_rdata[7:4]]) w_next = S_IMM;
          else if (is_io_op(w_new_op)) w_next = S_IO;
          else w_next = S_EXEC;
        end
      end
      S_IMM: begin
        w_req = 1'b1;
        if (w_done) begin
          if (w_cur_op == OP_LW || w_cur_op == OP_SW) w_next = S_MEM;
          else w_next = S_EXEC;
        end
      end
      S_EXEC: begin
        w_exec = 1'b1;
        if (w_cur_op == OP_LW) w_wb_sel = WB_MEM;
        else if (w_cur_op == OP_RO) w_wb_sel = WB_IO;
        w_next = S_FETCH;
      end
      S_MEM: begin
        w_req  = 1'b1;
        w_addr = r_imm;
        w_we   = (w_cur_op == OP_SW);
        if (w_done) begin
          // A store is complete once the bus accepts it; no execute cycle.
          if (w_cur_op == OP_SW) w_next = S_FETCH;
          else w_next = S_EXEC;
        end
      end
      S_IO: begin
        if (w_cur_op == OP_RO) begin
          w_rready = 1'b1;
          if (io_rvalid) w_next = S_EXEC;
        end else begin
          w_wvalid = 1'b1;
          if (io_wready) w_next = S_FETCH;
        end
      end
      default: w_next = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_FETCH;
      r_pc      <= RESET_PC;
      r_ir      <= 8'h00;
      r_imm     <= 8'h00;
      r_wb_data <= 8'h00;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_FETCH: begin
          if (w_done) begin
            r_ir <= w_rdata;
            r_pc <= r_pc + 8'd1;
          end
        end
        S_IMM: begin
          if (w_done) begin
            r_imm <= w_rdata;
            r_pc  <= r_pc + 8'd1;
          end
        end
        S_EXEC: begin
          if (w_cur_op == OP_JEQ && zero) r_pc <= r_imm;
        end
        S_MEM: begin
          if (w_done && w_cur_op == OP_LW) r_wb_data <= w_rdata;
        end
        S_IO: begin
          if (w_cur_op == OP_RO && io_rvalid) r_wb_data <= io_rdata;
        end
        default: ;
      endcase
    end
  end

  assign ir        = r_ir;
  assign imm       = r_imm;
  assign pc        = r_pc;
  assign wb_data   = r_wb_data;
  assign exec_en   = w_exec;
  assign wb_sel    = w_wb_sel;
  assign io_wvalid = w_wvalid;
  assign io_rready = w_rready;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: table of single-instruction programs
// plus hand sequences for reset mid-transfer, I/O stall and PC wrap.
module tb_instr_sequencer;
  import project_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT (RESET_PC = 00) ----------------
  logic       mem_req, mem_we, mem_ack;
  logic [7:0] mem_addr, mem_wdata, mem_rdata;
  logic [7:0] rt_data, io_rdata;
  logic       zero, io_wready, io_rvalid;
  logic [7:0] ir, imm, pc, wb_data;
  logic       exec_en, io_wvalid, io_rready;
  logic [1:0] wb_sel;
  e_seq_state dbg_state;

  instr_sequencer #(.RESET_PC(8'h00)) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .rt_data(rt_data), .zero(zero),
    .ir(ir), .imm(imm), .pc(pc), .exec_en(exec_en), .wb_sel(wb_sel),
    .wb_data(wb_data), .io_wvalid(io_wvalid), .io_wready(io_wready),
    .io_rvalid(io_rvalid), .io_rdata(io_rdata), .io_rready(io_rready),
    .dbg_state(dbg_state)
  );

  // ---------------- second DUT (RESET_PC = FF) ----------------
  logic       m2_req, m2_we, m2_ack;
  logic [7:0] m2_addr, m2_wdata, m2_rdata;
  logic [7:0] ir2, imm2, pc2, wb_data2;
  logic       exec_en2, io_wvalid2, io_rready2;
  logic [1:0] wb_sel2;
  e_seq_state dbg_state2;
  logic [7:0] tie8 = 8'h00;
  logic       tie0 = 1'b0;

  instr_sequencer #(.RESET_PC(8'hFF)) dut2 (
    .clk(clk), .rst_n(rst_n),
    .mem_req(m2_req), .mem_we(m2_we), .mem_addr(m2_addr),
    .mem_wdata(m2_wdata), .mem_rdata(m2_rdata), .mem_ack(m2_ack),
    .rt_data(tie8), .zero(tie0),
    .ir(ir2), .imm(imm2), .pc(pc2), .exec_en(exec_en2), .wb_sel(wb_sel2),
    .wb_data(wb_data2), .io_wvalid(io_wvalid2), .io_wready(tie0),
    .io_rvalid(tie0), .io_rdata(tie8), .io_rready(io_rready2),
    .dbg_state(dbg_state2)
  );

  // ---------------- memory model / monitors ----------------
  logic [7:0] mem [256];
  logic [7:0] slow_addr = 8'hF0;
  int         slow_delay = 0;
  int         wait_cnt = 0;
  bit         spurious_ack = 1'b0;
  int         exec_cnt, wr_cnt, we_cycles, slow_req_cnt, wstall_cnt;
  logic [1:0] last_wb_sel;
  logic [7:0] last_wr_addr, last_wr_data;

  initial begin
    mem_ack = 1'b0; mem_rdata = 8'h00;
    m2_ack = 1'b0; m2_rdata = 8'h00;
  end

  always @(negedge clk) begin
    if (exec_en) begin exec_cnt++; last_wb_sel = wb_sel; end
    if (io_wvalid && !io_wready) wstall_cnt++;
    if (mem_req && mem_we) we_cycles++;
    if (mem_req && mem_addr == slow_addr) slow_req_cnt++;
    mem_ack = 1'b0;
    if (!rst_n || !mem_req) begin
      wait_cnt = 0;
      if (rst_n && spurious_ack) begin mem_ack = 1'b1; mem_rdata = 8'hEE; end
    end else if (mem_addr == slow_addr && wait_cnt < slow_delay) begin
      wait_cnt++;
    end else begin
      mem_ack = 1'b1;
      mem_rdata = mem[mem_addr];
      wait_cnt = 0;
      if (mem_we) begin
        mem[mem_addr] = mem_wdata;
        wr_cnt++;
        last_wr_addr = mem_addr;
        last_wr_data = mem_wdata;
      end
    end
  end

  // Zero-wait read-only responder for the wrap-test instance.
  always @(negedge clk) begin
    m2_ack = rst_n && m2_req;
    m2_rdata = mem[m2_addr];
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic start_program(input logic [7:0] b0, input logic [7:0] b1);
    tick(1);
    rst_n = 1'b0;
    for (int a = 0; a < 256; a++) mem[a] = 8'h00;
    mem[0] = b0;
    mem[1] = b1;
    exec_cnt = 0; wr_cnt = 0; we_cycles = 0; slow_req_cnt = 0; wstall_cnt = 0;
    last_wb_sel = 2'd0; last_wr_addr = 8'h00; last_wr_data = 8'h00;
    spurious_ack = 1'b0;
    tick(2);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [7:0] b0;
    logic [7:0] b1;
    logic       zero;
    logic [7:0] rt;
    logic [7:0] slow_addr;
    int         slow_delay;
    logic [7:0] slow_data;
    logic       io_rdy;
    logic [7:0] io_rd;
    int         lat;
    logic [7:0] exp_pc;
    logic [7:0] exp_imm;
    int         exp_exec;
    logic [1:0] exp_wb_sel;
    logic [7:0] exp_wb_data;
    int         exp_wr;
  } vec_t;

  vec_t vecs[11];

  initial begin
    automatic bit found;
    zero = 1'b0; rt_data = 8'h00; io_wready = 1'b0; io_rvalid = 1'b0; io_rdata = 8'h00;

    //          b0     b1     z     rt     slowA  dly slowD  io    iord   lat pc     imm    ex wbs   wbd    wr
    vecs[0]  = '{8'h16, 8'h00, 1'b0, 8'h00, 8'hF0, 0, 8'h00, 1'b0, 8'h00, 2, 8'h01, 8'h00, 1, 2'd0, 8'h00, 0}; // ADD
    vecs[1]  = '{8'h00, 8'h55, 1'b0, 8'h00, 8'hF0, 0, 8'h00, 1'b0, 8'h00, 2, 8'h01, 8'h00, 1, 2'd0, 8'h00, 0}; // NOP
    vecs[2]  = '{8'hF5, 8'h00, 1'b0, 8'h00, 8'hF0, 0, 8'h00, 1'b0, 8'h00, 2, 8'h01, 8'h00, 1, 2'd0, 8'h00, 0}; // unused
    vecs[3]  = '{8'h94, 8'h00, 1'b0, 8'h00, 8'hF0, 0, 8'h00, 1'b0, 8'h00, 2, 8'h01, 8'h00, 1, 2'd0, 8'h00, 0}; // COPY
    vecs[4]  = '{8'h24, 8'h07, 1'b0, 8'h00, 8'hF0, 0, 8'h00, 1'b0, 8'h00, 3, 8'h02, 8'h07, 1, 2'd0, 8'h00, 0}; // ADDI
    vecs[5]  = '{8'hC1, 8'h40, 1'b1, 8'h00, 8'hF0, 0, 8'h00, 1'b0, 8'h00, 3, 8'h40, 8'h40, 1, 2'd0, 8'h00, 0}; // JEQ taken
    vecs[6]  = '{8'hC1, 8'h40, 1'b0, 8'h00, 8'hF0, 0, 8'h00, 1'b0, 8'h00, 3, 8'h02, 8'h40, 1, 2'd0, 8'h00, 0}; // JEQ not
    vecs[7]  = '{8'h72, 8'hA0, 1'b0, 8'h00, 8'hA0, 2, 8'h5A, 1'b0, 8'h00, 6, 8'h02, 8'hA0, 1, 2'd1, 8'h5A, 0}; // LW slow
    vecs[8]  = '{8'h85, 8'h33, 1'b0, 8'h9C, 8'hF0, 0, 8'h00, 1'b0, 8'h00, 3, 8'h02, 8'h33, 0, 2'd0, 8'h00, 1}; // SW
    vecs[9]  = '{8'hB0, 8'h00, 1'b0, 8'h00, 8'hF0, 0, 8'h00, 1'b1, 8'hC3, 3, 8'h01, 8'h00, 1, 2'd2, 8'hC3, 0}; // RO
    vecs[10] = '{8'hA0, 8'h00, 1'b0, 8'h00, 8'hF0, 0, 8'h00, 1'b1, 8'h00, 2, 8'h01, 8'h00, 0, 2'd0, 8'h00, 0}; // WO

    // Reset state while rst_n is held low.
    tick(2);
    check("rst_pc", 16'(pc), 16'h00);
    check("rst_ir", 16'(ir), 16'h00);
    check("rst_imm", 16'(imm), 16'h00);
    check("rst_wb_data", 16'(wb_data), 16'h00);
    check("rst_mem_req", 16'(mem_req), 16'h0);
    check("rst_strobes", {12'h0, exec_en, io_wvalid, io_rready, mem_we}, 16'h0);
    check("rst_wb_sel", 16'(wb_sel), 16'h0);
    check("rst_state", 16'(dbg_state), 16'(S_FETCH));
    check("rst_pc2", 16'(pc2), 16'hFF);

    for (int i = 0; i < 11; i++) begin
      start_program(vecs[i].b0, vecs[i].b1);
      zero = vecs[i].zero;
      rt_data = vecs[i].rt;
      slow_addr = vecs[i].slow_addr;
      slow_delay = vecs[i].slow_delay;
      mem[vecs[i].slow_addr] = vecs[i].slow_data;
      io_wready = vecs[i].io_rdy;
      io_rvalid = vecs[i].io_rdy;
      io_rdata = vecs[i].io_rd;
      rst_n = 1'b1;
      tick(vecs[i].lat);
      check($sformatf("v%0d_state", i), 16'(dbg_state), 16'(S_FETCH));
      check($sformatf("v%0d_pc", i), 16'(pc), 16'(vecs[i].exp_pc));
      check($sformatf("v%0d_fetch_addr", i), 16'(mem_addr), 16'(vecs[i].exp_pc));
      check($sformatf("v%0d_ir", i), 16'(ir), 16'(vecs[i].b0));
      check($sformatf("v%0d_imm", i), 16'(imm), 16'(vecs[i].exp_imm));
      check($sformatf("v%0d_exec_cnt", i), 16'(exec_cnt), 16'(vecs[i].exp_exec));
      check($sformatf("v%0d_wb_sel", i), 16'(last_wb_sel), 16'(vecs[i].exp_wb_sel));
      check($sformatf("v%0d_wb_data", i), 16'(wb_data), 16'(vecs[i].exp_wb_data));
      check($sformatf("v%0d_writes", i), 16'(wr_cnt), 16'(vecs[i].exp_wr));
      check($sformatf("v%0d_we_cycles", i), 16'(we_cycles), 16'(vecs[i].exp_wr));
      check($sformatf("v%0d_slow_req", i), 16'(slow_req_cnt),
            16'(vecs[i].slow_delay > 0 ? vecs[i].slow_delay + 1 : 0));
      if (vecs[i].exp_wr > 0) begin
        check($sformatf("v%0d_wr_addr", i), 16'(last_wr_addr), 16'(vecs[i].b1));
        check($sformatf("v%0d_wr_data", i), 16'(last_wr_data), 16'(vecs[i].rt));
      end
    end
    io_wready = 1'b0; io_rvalid = 1'b0; zero = 1'b0;

    // Reset asserted while a store is stalled in MEM.
    start_program(8'h85, 8'h33);
    rt_data = 8'h9C;
    slow_addr = 8'h33;
    slow_delay = 20;
    rst_n = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      if (dbg_state == S_MEM) found = 1'b1;
      else tick(1);
    end
    check("rstmem_reach_mem", 16'(found), 16'h1);
    tick(2);
    check("rstmem_req_before", 16'(mem_req), 16'h1);
    rst_n = 1'b0;
    #1;
    check("rstmem_req_drop", 16'(mem_req), 16'h0);
    check("rstmem_we_drop", 16'(mem_we), 16'h0);
    check("rstmem_pc", 16'(pc), 16'h00);
    check("rstmem_state", 16'(dbg_state), 16'(S_FETCH));
    check("rstmem_exec", 16'(exec_en), 16'h0);
    tick(1);
    check("rstmem_no_write", 16'(wr_cnt), 16'h0);
    slow_delay = 0;
    rst_n = 1'b1;
    #1;
    check("rstmem_first_req", 16'(mem_req), 16'h1);
    check("rstmem_first_addr", 16'(mem_addr), 16'h00);

    // WO with io_wready low for 4 cycles; a stray ack meanwhile is ignored.
    start_program(8'hA0, 8'h00);
    io_wready = 1'b0;
    rst_n = 1'b1;
    tick(1);
    check("wo_state_io", 16'(dbg_state), 16'(S_IO));
    spurious_ack = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick(1);
      check($sformatf("wo_pc_frozen%0d", k), 16'(pc), 16'h01);
      check($sformatf("wo_wvalid%0d", k), 16'(io_wvalid), 16'h1);
    end
    spurious_ack = 1'b0;
    check("wo_ir_kept", 16'(ir), 16'hA0);
    check("wo_stall_cycles", 16'(wstall_cnt), 16'd4);
    io_wready = 1'b1;
    tick(1);
    check("wo_done_state", 16'(dbg_state), 16'(S_FETCH));
    check("wo_no_exec", 16'(exec_cnt), 16'h0);
    check("wo_pc_after", 16'(pc), 16'h01);
    io_wready = 1'b0;

    // PC wrap: ADDI at FF takes its immediate from address 00.
    start_program(8'h07, 8'h00);
    mem[8'hFF] = 8'h20;
    rst_n = 1'b1;
    tick(3);
    check("wrap_state", 16'(dbg_state2), 16'(S_FETCH));
    check("wrap_ir", 16'(ir2), 16'h20);
    check("wrap_imm", 16'(imm2), 16'h07);
    check("wrap_pc", 16'(pc2), 16'h01);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
